// File: rtl/univ_shift_seq_if.sv
// Command channel between an upstream controller and the universal shift sequencer.
// The master drives the command fields; the slave returns cmd_ready.
interface univ_shift_seq_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_fill;
   logic [CNT_W-1:0] cmd_count;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      output cmd_fill,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      input  cmd_fill,
      input  cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/univ_shift_seq.sv
// Sequencer that turns load/shift/rotate commands into the per-cycle sel/ser_in/par_out
// stream for a downstream universal shift register.
module univ_shift_seq #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   univ_shift_seq_if.slave      cmd,
   input  logic [WIDTH-1:0]     reg_q,
   output logic [1:0]           sel,
   output logic                 ser_in,
   output logic [WIDTH-1:0]     par_out,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] OpLoad  = 2'b00;
   localparam logic [1:0] OpShl   = 2'b10;
   localparam logic [1:0] OpRot   = 2'b11;

   localparam logic [1:0] SelHold = 2'b00;
   localparam logic [1:0] SelShr  = 2'b01;
   localparam logic [1:0] SelShl  = 2'b10;
   localparam logic [1:0] SelLoad = 2'b11;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic             fill_q;
   logic [1:0]       sel_q;
   logic [WIDTH-1:0] par_out_q;
   logic             busy_q;
   logic             done_q;
   logic             ready_q;

   // Only the LSB of the register matters: it is the bit fed back for rotate right.
   logic unused_reg_q;
   assign unused_reg_q = ^reg_q[WIDTH-1:1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= OpLoad;
         fill_q    <= 1'b0;
         sel_q     <= SelHold;
         par_out_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd.cmd_valid && ready_q) begin
                  op_q      <= cmd.cmd_op;
                  fill_q    <= cmd.cmd_fill;
                  cnt_q     <= cmd.cmd_count;
                  par_out_q <= cmd.cmd_data;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
                  if (cmd.cmd_op == OpLoad) begin
                     state_q <= StLoad;
                     sel_q   <= SelLoad;
                  end else if (cmd.cmd_count != '0) begin
                     state_q <= StShift;
                     sel_q   <= (cmd.cmd_op == OpShl) ? SelShl : SelShr;
                  end else begin
                     state_q <= StDone;
                     sel_q   <= SelHold;
                     done_q  <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state_q <= StDone;
               sel_q   <= SelHold;
               done_q  <= 1'b1;
            end
            StShift: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= StDone;
                  sel_q   <= SelHold;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
               sel_q   <= SelHold;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Rotate feeds the register's own LSB straight back, so it cannot be registered.
   assign ser_in        = (state_q == StShift) ? ((op_q == OpRot) ? reg_q[0] : fill_q) : 1'b0;
   assign sel           = sel_q;
   assign par_out       = par_out_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Bench for univ_shift_seq: a behavioural 4-bit universal register closes the loop
// and a vector table drives load/shift/rotate commands.
module tb_univ_shift_seq;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] reg_q = '0;
   logic [1:0]       sel;
   logic             ser_in;
   logic [WIDTH-1:0] par_out;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;

   univ_shift_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_bus ();

   univ_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .cmd     (cmd_bus),
      .reg_q   (reg_q),
      .sel     (sel),
      .ser_in  (ser_in),
      .par_out (par_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Downstream universal shift register
   always @(posedge clk) begin
      case (sel)
         2'b01:   reg_q <= {ser_in, reg_q[3:1]};
         2'b10:   reg_q <= {reg_q[2:0], ser_in};
         2'b11:   reg_q <= par_out;
         default: ;
      endcase
   end

   typedef struct {
      logic [1:0] op;
      logic [3:0] data;
      logic       fill;
      logic [2:0] cnt;
      logic [3:0] exp_q;
      logic [1:0] exp_sel;
      int         exp_act;
      int         exp_done;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Issue one command and watch it until the sequencer is ready again.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic fill,
                          input logic [2:0] cnt, input logic [1:0] exp_sel,
                          output int act, output int done_idx, output int done_n,
                          output int err);
      bit back = 1'b0;
      act = 0; done_idx = -1; done_n = 0; err = 0;
      @(negedge clk);
      if (cmd_bus.cmd_ready !== 1'b1) err++;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_data  = data;
      cmd_bus.cmd_fill  = fill;
      cmd_bus.cmd_count = cnt;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) begin
            cmd_bus.cmd_valid = 1'b0;
            cmd_bus.cmd_data  = ~data;
            cmd_bus.cmd_fill  = ~fill;
         end
         if (cmd_bus.cmd_ready === 1'b1) begin
            back = 1'b1;
            break;
         end
         if (busy !== 1'b1) err++;
         if (sel !== 2'b00) begin
            act++;
            if (sel !== exp_sel) err++;
            if (sel === 2'b11) begin
               if (par_out !== data) err++;
            end else if (ser_in !== ((op == 2'b11) ? reg_q[0] : fill)) begin
               err++;
            end
         end else if (ser_in !== 1'b0) begin
            err++;
         end
         if (done === 1'b1) begin
            done_n++;
            if (done_idx < 0) done_idx = c;
         end
      end
      if (!back) err++;
   endtask

   initial begin
      int act, didx, dn, err;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = 2'b00;
      cmd_bus.cmd_data  = 4'b0000;
      cmd_bus.cmd_fill  = 1'b0;
      cmd_bus.cmd_count = 3'd0;

      //           op     data     fill  cnt   exp_q    sel    act done
      vecs[0]  = '{2'b00, 4'b1011, 1'b0, 3'd0, 4'b1011, 2'b11, 1, 1};
      vecs[1]  = '{2'b00, 4'b0000, 1'b0, 3'd0, 4'b0000, 2'b11, 1, 1};
      vecs[2]  = '{2'b01, 4'b0000, 1'b1, 3'd2, 4'b1100, 2'b01, 2, 2};
      vecs[3]  = '{2'b00, 4'b1011, 1'b0, 3'd0, 4'b1011, 2'b11, 1, 1};
      vecs[4]  = '{2'b10, 4'b0000, 1'b0, 3'd3, 4'b1000, 2'b10, 3, 3};
      vecs[5]  = '{2'b00, 4'b1011, 1'b0, 3'd0, 4'b1011, 2'b11, 1, 1};
      vecs[6]  = '{2'b11, 4'b0000, 1'b0, 3'd1, 4'b1101, 2'b01, 1, 1};
      vecs[7]  = '{2'b00, 4'b1011, 1'b0, 3'd0, 4'b1011, 2'b11, 1, 1};
      vecs[8]  = '{2'b11, 4'b0000, 1'b0, 3'd4, 4'b1011, 2'b01, 4, 4};
      vecs[9]  = '{2'b01, 4'b0000, 1'b0, 3'd7, 4'b0000, 2'b01, 7, 7};
      vecs[10] = '{2'b10, 4'b0000, 1'b1, 3'd0, 4'b0000, 2'b00, 0, 0};
      vecs[11] = '{2'b00, 4'b0110, 1'b0, 3'd0, 4'b0110, 2'b11, 1, 1};
      vecs[12] = '{2'b11, 4'b0000, 1'b0, 3'd3, 4'b1100, 2'b01, 3, 3};

      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_ser_in", 32'(ser_in), 32'd0);
      check("rst_par_out", 32'(par_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_cmd(vecs[i].op, vecs[i].data, vecs[i].fill, vecs[i].cnt, vecs[i].exp_sel,
                 act, didx, dn, err);
         check($sformatf("v%0d_reg_q", i), 32'(reg_q), 32'(vecs[i].exp_q));
         check($sformatf("v%0d_sel_cycles", i), act, vecs[i].exp_act);
         check($sformatf("v%0d_done_cycle", i), didx, vecs[i].exp_done);
         check($sformatf("v%0d_done_pulses", i), dn, 1);
         check($sformatf("v%0d_cycle_errors", i), err, 0);
      end

      // Second command held valid through the first; taken only back in idle.
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = 2'b00;
      cmd_bus.cmd_data  = 4'b0101;
      @(negedge clk);
      check("hold_c0_sel", 32'(sel), 32'd3);
      check("hold_c0_par_out", 32'(par_out), 32'(4'b0101));
      cmd_bus.cmd_data = 4'b1110;
      @(negedge clk);
      check("hold_c1_done", 32'(done), 32'd1);
      check("hold_c1_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      @(negedge clk);
      check("hold_c2_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      check("hold_c2_sel", 32'(sel), 32'd0);
      @(negedge clk);
      check("hold_c3_sel", 32'(sel), 32'd3);
      check("hold_c3_par_out", 32'(par_out), 32'(4'b1110));
      cmd_bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("hold_c4_done", 32'(done), 32'd1);
      check("hold_reg_q", 32'(reg_q), 32'(4'b1110));
      @(negedge clk);

      // Reset two steps into a five-step shift.
      run_cmd(2'b00, 4'b1111, 1'b0, 3'd0, 2'b11, act, didx, dn, err);
      check("pre_rst_load_errors", err, 0);
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = 2'b01;
      cmd_bus.cmd_data  = 4'b1111;
      cmd_bus.cmd_fill  = 1'b0;
      cmd_bus.cmd_count = 3'd5;
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b0;
      check("mid_c0_sel", 32'(sel), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("mid_two_steps_reg_q", 32'(reg_q), 32'(4'b0011));
      reset = 1'b0;
      #1;
      check("mid_rst_sel", 32'(sel), 32'd0);
      check("mid_rst_ser_in", 32'(ser_in), 32'd0);
      check("mid_rst_par_out", 32'(par_out), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      @(negedge clk);
      check("mid_rst_hold_done", 32'(done), 32'd0);
      check("mid_rst_hold_reg_q", 32'(reg_q), 32'(4'b0011));
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_reg_q", 32'(reg_q), 32'(4'b0011));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
